// File: rtl/enc_onehot2bin_skid_if.sv
// enc_onehot2bin_skid_if: upstream one-hot word channel, downstream binary
// index channel and the error counter of enc_onehot2bin_skid in one bundle.
// slave is the encoder side, master is the producer/consumer side.
interface enc_onehot2bin_skid_if #(
   parameter int unsigned W         = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   localparam int unsigned N = (32'd1 << W) - 32'd1;

   logic                 in_valid;
   logic [N-1:0]         in;
   logic                 in_ready;
   logic                 out_valid;
   logic [W-1:0]         out;
   logic                 out_err;
   logic                 out_ready;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, out_err, err_cnt
   );

   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, out_err, err_cnt
   );
endinterface

// File: rtl/enc_onehot2bin_skid.sv
// enc_onehot2bin_skid: re-encodes a 15-bit one-hot word to a 4-bit index,
// flags and counts illegal (multi-hot) words, and buffers results in a
// 2-entry skid FIFO behind a valid/ready handshake.
// Build option: define ONEHOT_PRIORITY_EN to encode multi-hot words to their
// lowest set bit instead of code N. All outputs come straight from flops.
module enc_onehot2bin_skid #(
   parameter int unsigned W         = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   enc_onehot2bin_skid_if.slave    io_bus
);
   localparam int unsigned N = (32'd1 << W) - 32'd1;

   typedef struct packed {
      logic [W-1:0] code;
      logic         err;
   } entry_t;

   entry_t               w_enc;
   logic                 w_seen;
   logic                 w_multi;
   logic [W-1:0]         w_low;

   entry_t               r_mem [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;
   logic                 r_in_ready;
   logic                 r_out_valid;
   entry_t               r_head;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_wr_ptr_nxt;
   logic                 w_rd_ptr_nxt;
   logic [1:0]           w_count_nxt;
   entry_t               w_head_nxt;
   logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

   assign w_push = io_bus.in_valid & r_in_ready;
   assign w_pop  = r_out_valid & io_bus.out_ready;

   // Encode: find lowest set bit and whether more than one bit is set
   always_comb begin
      w_seen  = 1'b0;
      w_multi = 1'b0;
      w_low   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (io_bus.in[k]) begin
            if (w_seen) w_multi = 1'b1;
            else        w_low   = W'(k);
            w_seen = 1'b1;
         end
      end
      w_enc.err = w_multi;
      if (!w_seen) begin
         w_enc.code = W'(N);
      end else if (w_multi) begin
`ifdef ONEHOT_PRIORITY_EN
         w_enc.code = w_low;
`else
         w_enc.code = W'(N);
`endif
      end else begin
         w_enc.code = w_low;
      end
   end

   // Next occupancy, pointers, head entry and error count
   always_comb begin
      w_wr_ptr_nxt  = r_wr_ptr;
      w_rd_ptr_nxt  = r_rd_ptr;
      w_count_nxt   = r_count;
      w_head_nxt    = '0;
      w_err_cnt_nxt = r_err_cnt;

      if (w_push) w_wr_ptr_nxt = ~r_wr_ptr;
      if (w_pop)  w_rd_ptr_nxt = ~r_rd_ptr;

      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase

      // New head bypasses the array when it is being written this cycle
      if (w_count_nxt != 2'd0) begin
         if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = w_enc;
         else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
      end

      if (w_push && w_enc.err && (r_err_cnt != '1))
         w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
   end

   // FIFO storage write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_enc;
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_head      <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_count     <= w_count_nxt;
         r_in_ready  <= (w_count_nxt != 2'd2);
         r_out_valid <= (w_count_nxt != 2'd0);
         r_head      <= w_head_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out       = r_head.code;
   assign io_bus.out_err   = r_head.err;
   assign io_bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_enc_onehot2bin_skid.sv
// Testbench for enc_onehot2bin_skid: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_enc_onehot2bin_skid;
   localparam int unsigned W  = 4;
   localparam int unsigned N  = 15;
   localparam int unsigned EC = 8;
   localparam int unsigned VW = 2 + W + EC;

   typedef struct {
      logic [W-1:0] code;
      logic         err;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   ent_t q[$];
   int   m_cnt  = 0;
   bit   m_live = 0;

   enc_onehot2bin_skid_if #(.W(W), .ERR_CNT_W(EC)) bus ();

   enc_onehot2bin_skid #(.W(W), .ERR_CNT_W(EC)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Reference encoder from the word's population count
   function automatic ent_t ref_enc(input logic [N-1:0] v);
      ent_t e;
      int   n;
      logic [N-1:0] lsb;
      n   = $countones(v);
      lsb = v & (~v + N'(1));
      if (n == 0) begin
         e.code = W'(15); e.err = 1'b0;
      end else if (n == 1) begin
         e.code = W'($clog2(v)); e.err = 1'b0;
      end else begin
`ifdef ONEHOT_PRIORITY_EN
         e.code = W'($clog2(lsb));
`else
         e.code = W'(15);
`endif
         e.err = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      if (q.size() == 0) return {1'b0, 4'h0, 1'b0, EC'(m_cnt)};
      return {1'b1, q[0].code, q[0].err, EC'(m_cnt)};
   endfunction

   function automatic logic exp_rdy();
      return m_live && (q.size() < 2);
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {bus.out_valid, bus.out, bus.out_err, bus.err_cnt};
   endfunction

   // Drive one cycle from a negedge, update the model at the posedge
   task automatic cycle(input logic v, input logic [N-1:0] d, input logic r);
      bit push, pop;
      bus.in_valid  = v;
      bus.in        = d;
      bus.out_ready = r;
      push = v && exp_rdy();
      pop  = (q.size() > 0) && r;
      @(posedge clk);
      if (!rst) begin
         if (pop) void'(q.pop_front());
         if (push) begin
            ent_t e;
            e = ref_enc(d);
            q.push_back(e);
            if (e.err && m_cnt < 255) m_cnt++;
         end
         m_live = 1;
      end
      @(negedge clk);
   endtask

   task automatic model_clear();
      q.delete();
      m_cnt  = 0;
      m_live = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      model_clear();
      n_checks++;
      if (obs_vec() !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h exp %h", obs_vec(), {VW{1'b0}});
      end
      rst = 1'b0;
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_idle: got %h exp %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_stream();
      logic [N-1:0] words [3];
      logic [W-1:0] codes [3];
      logic [VW-1:0] want;
      words = '{15'h0001, 15'h0400, 15'h4000};
      codes = '{4'd0, 4'd10, 4'd14};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, words[i], 1'b1);
         want = {1'b1, codes[i], 1'b0, 8'd0};
         n_checks++;
         if (obs_vec() !== want) begin
            n_fail++; $display("FAIL stream_%0d: got %h exp %h", i, obs_vec(), want);
         end
      end
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (obs_vec() !== {1'b0, 4'h0, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL stream_drain: got %h exp 0", obs_vec());
      end
   endtask

   task automatic test_zero();
      cycle(1'b1, 15'h0000, 1'b1);
      n_checks++;
      if (obs_vec() !== {1'b1, 4'hF, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL zero_vector: got %h exp %h", obs_vec(), {1'b1, 4'hF, 1'b0, 8'd0});
      end
      cycle(1'b0, '0, 1'b1);
   endtask

   task automatic test_multi();
      logic [VW-1:0] want;
`ifdef ONEHOT_PRIORITY_EN
      want = {1'b1, 4'd2, 1'b1, 8'd1};
`else
      want = {1'b1, 4'hF, 1'b1, 8'd1};
`endif
      cycle(1'b1, 15'h0014, 1'b1);
      n_checks++;
      if (obs_vec() !== want) begin
         n_fail++; $display("FAIL multi_hot: got %h exp %h", obs_vec(), want);
      end
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.err_cnt !== 8'd1) begin
         n_fail++; $display("FAIL multi_hot_cnt_hold: got %0d exp 1", bus.err_cnt);
      end
   endtask

   task automatic test_backpressure();
      cycle(1'b1, 15'h0002, 1'b0);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b1, 1'b1, 4'd1, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL bp_first: got %h", {bus.in_ready, obs_vec()});
      end
      cycle(1'b1, 15'h0008, 1'b0);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b0, 1'b1, 4'd1, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL bp_full: got %h", {bus.in_ready, obs_vec()});
      end
      cycle(1'b1, 15'h0020, 1'b0);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b0, 1'b1, 4'd1, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL bp_hold: got %h", {bus.in_ready, obs_vec()});
      end
      cycle(1'b1, 15'h0020, 1'b1);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b1, 1'b1, 4'd3, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL bp_second: got %h", {bus.in_ready, obs_vec()});
      end
      cycle(1'b1, 15'h0020, 1'b1);
      n_checks++;
      if (obs_vec() !== {1'b1, 4'd5, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL bp_third: got %h", obs_vec());
      end
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_drain: got %h exp %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_push_pop();
      cycle(1'b1, 15'h0100, 1'b0);
      cycle(1'b1, 15'h1000, 1'b1);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b1, 1'b1, 4'd12, 1'b0, EC'(m_cnt)}) begin
         n_fail++; $display("FAIL push_pop_head: got %h", {bus.in_ready, obs_vec()});
      end
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL push_pop_single: got out_valid %b exp 0", bus.out_valid);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] d;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(3))
            0:       d = '0;
            1:       d = N'(1) << $urandom_range(14);
            2:       d = (N'(1) << $urandom_range(14)) | (N'(1) << $urandom_range(14));
            default: d = N'($urandom);
         endcase
         cycle(1'($urandom_range(1)), d, 1'($urandom_range(3) != 0));
         n_checks++;
         if ({bus.in_ready, obs_vec()} !== {exp_rdy(), exp_vec()}) begin
            n_fail++;
            $display("FAIL random_%0d: got %h exp %h", i, {bus.in_ready, obs_vec()}, {exp_rdy(), exp_vec()});
         end
      end
   endtask

   task automatic test_saturation_reset();
      for (int i = 0; i < 300; i++)
         cycle(1'b1, 15'h0003 | N'($urandom), 1'b1);
      n_checks++;
      if (bus.err_cnt !== 8'd255) begin
         n_fail++; $display("FAIL saturate: got %0d exp 255", bus.err_cnt);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL saturate_model: got %h exp %h", obs_vec(), exp_vec());
      end
      bus.in_valid = 1'b1; bus.in = 15'h0040; bus.out_ready = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (obs_vec() !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h exp 0", obs_vec());
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      model_clear();
      rst = 1'b0;
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if ({bus.in_ready, obs_vec()} !== {1'b1, {VW{1'b0}}}) begin
         n_fail++; $display("FAIL post_reset: got %h exp %h", {bus.in_ready, obs_vec()}, {1'b1, {VW{1'b0}}});
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_zero();
      test_multi();
      test_backpressure();
      test_push_pop();
      test_random();
      test_saturation_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
